y_fetch_queue: RTL and testbench

- Decoupled instruction-fetch front end. Sits directly upstream of the decode stage (yID) and replaces the single-cycle yIF fetch path.
- Streams sequential word addresses to instruction memory over a req/gnt request channel and an in-order rvalid response channel.
- Buffers returned instructions with their PC in a FIFO and presents them to decode over a valid/ready handshake.
- A redirect (branch, jump or INT from yPC) flushes the queue, discards in-flight responses and restarts fetch at the new target.

---
 rtl/y_fetch_queue_if.sv | 53 +++++
 rtl/y_fetch_queue.sv | 156 +++++++++++++++
 tb/tb_y_fetch_queue.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/y_fetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | y_fetch_queue_if                                                           |
// | Redirect, imem request/response and decode handshake bundle for the queue. |
// | Stats ports exist only when FETCH_QUEUE_STATS_EN is defined.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface y_fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                     redirect;
    logic [31:0]              redirect_pc;
    logic                     imem_req;
    logic [31:0]              imem_addr;
    logic                     imem_gnt;
    logic                     imem_rvalid;
    logic [31:0]              imem_rdata;
    logic                     ins_valid;
    logic [31:0]              ins;
    logic [31:0]              PC;
    logic [31:0]              PCp4;
    logic                     ins_ready;
    logic [$clog2(DEPTH):0]   count;
`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0]              stat_flushed;
    logic [15:0]              stat_starve;
`endif

    modport master (
        input  redirect, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output ins_valid, ins, PC, PCp4,
        input  ins_ready,
        output count
`ifdef FETCH_QUEUE_STATS_EN
        , output stat_flushed, stat_starve
`endif
    );

    modport slave (
        output redirect, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  ins_valid, ins, PC, PCp4,
        output ins_ready,
        input  count
`ifdef FETCH_QUEUE_STATS_EN
        , input stat_flushed, stat_starve
`endif
    );
endinterface
`default_nettype wire

// File: rtl/y_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | y_fetch_queue                                                              |
// | Decoupled fetch front end: credit-limited imem requests, instruction FIFO, |
// | redirect flush. Optional counters under FETCH_QUEUE_STATS_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module y_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h28
) (
    input  wire logic       clk,
    input  wire logic       rst,
    y_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [TW-1:0] c_TAG_LAST = TW'(MAX_OUT - 1);
    localparam logic [CW:0]   c_DEPTH    = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] c_MAX_OUT  = CW'(MAX_OUT);

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_disc;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_ins_mem [DEPTH];
    logic [31:0]   r_pc_mem  [DEPTH];
    logic [31:0]   r_tag     [MAX_OUT];
    logic [TW-1:0] r_tag_rd;
    logic [TW-1:0] r_tag_wr;

    logic [CW:0]   w_credit;
    logic          w_req;
    logic          w_grant;
    logic          w_rsp;
    logic          w_drop;
    logic          w_push;
    logic          w_valid;
    logic          w_pop;
    logic [CW-1:0] w_out_next;
    logic [31:0]   w_target;

    // Queued entries plus responses still owed to the queue must fit in DEPTH.
    assign w_credit   = {1'b0, r_count} + {1'b0, r_out} - {1'b0, r_disc};
    assign w_req      = !rst && !bus.redirect && (r_out < c_MAX_OUT) && (w_credit < c_DEPTH);
    assign w_grant    = w_req && bus.imem_gnt;
    assign w_rsp      = bus.imem_rvalid && (r_out != '0);
    assign w_drop     = w_rsp && (r_disc != '0);
    assign w_push     = w_rsp && !w_drop;
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && bus.ins_ready;
    assign w_out_next = r_out + CW'(w_grant) - CW'(w_rsp);
    assign w_target   = bus.redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_out      <= '0;
            r_disc     <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_out <= w_out_next;
            if (bus.redirect) begin
                // Every response still in flight belongs to the abandoned stream.
                r_fetch_pc <= w_target;
                r_disc     <= w_out_next;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_drop)  r_disc     <= r_disc - CW'(1);
                if (w_push)  r_wr_ptr   <= r_wr_ptr + AW'(1);
                if (w_pop)   r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ins_mem[i] <= '0;
                r_pc_mem[i]  <= '0;
            end
        end else if (w_push && !bus.redirect) begin
            r_ins_mem[r_wr_ptr] <= bus.imem_rdata;
            r_pc_mem[r_wr_ptr]  <= r_tag[r_tag_rd];
        end
    end

    // Issued addresses, popped by every response (kept or dropped) in order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                r_tag[i] <= '0;
            end
            r_tag_rd <= '0;
            r_tag_wr <= '0;
        end else begin
            if (w_grant) begin
                r_tag[r_tag_wr] <= r_fetch_pc;
                r_tag_wr        <= (r_tag_wr == c_TAG_LAST) ? '0 : r_tag_wr + TW'(1);
            end
            if (w_rsp) begin
                r_tag_rd <= (r_tag_rd == c_TAG_LAST) ? '0 : r_tag_rd + TW'(1);
            end
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.ins_valid = w_valid;
    assign bus.ins       = r_ins_mem[r_rd_ptr];
    assign bus.PC        = r_pc_mem[r_rd_ptr];
    assign bus.PCp4      = r_pc_mem[r_rd_ptr] + 32'd4;
    assign bus.count     = r_count;

`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] r_flushed;
    logic [15:0] r_starve;
    logic        r_delivered;
    logic [16:0] w_flush_inc;
    logic [16:0] w_flush_sum;

    // A response landing in the redirect cycle is lost too, so it is counted.
    assign w_flush_inc = (bus.redirect ? 17'(r_count) : 17'd0)
                       + 17'(w_rsp && (bus.redirect || (r_disc != '0)));
    assign w_flush_sum = {1'b0, r_flushed} + w_flush_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flushed   <= '0;
            r_starve    <= '0;
            r_delivered <= 1'b0;
        end else begin
            r_flushed <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
            if (r_delivered && !w_valid && !bus.redirect && (r_starve != 16'hFFFF)) begin
                r_starve <= r_starve + 16'd1;
            end
            if (w_pop && !bus.redirect) r_delivered <= 1'b1;
        end
    end

    assign bus.stat_flushed = r_flushed;
    assign bus.stat_starve  = r_starve;
`endif
endmodule
`default_nettype wire

// File: tb/tb_y_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_y_fetch_queue                                                           |
// | Randomized bench with an epoch-based reference model of the fetch queue.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_y_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h28;

    logic clk = 1'b0;
    logic rst;

    y_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    y_fetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] q_pc[$];
    int          epoch;
    int          cyc;
    int          last_due;
    logic [31:0] m_fetch;
    int          m_flushed;
    int          m_starve;
    bit          m_delivered;

    int gnt_pct, rv_pct, max_lat, rdy_pct, redir_pct;
    bit          force_redir;
    logic [31:0] force_pc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic model_reset();
        pend.delete();
        q_pc.delete();
        epoch       = 0;
        last_due    = 0;
        m_fetch     = RESET_PC;
        m_flushed   = 0;
        m_starve    = 0;
        m_delivered = 0;
    endtask

    task automatic drive_idle();
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.ins_ready   = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_req",   32'(bus.imem_req),  32'd0);
        chk("rst_addr",  bus.imem_addr,      RESET_PC);
        chk("rst_valid", 32'(bus.ins_valid), 32'd0);
        chk("rst_count", 32'(bus.count),     32'd0);
        chk("rst_ins",   bus.ins,            32'd0);
        chk("rst_pc",    bus.PC,             32'd0);
        chk("rst_pcp4",  bus.PCp4,           32'd4);
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3))
            0:       return 32'h100 + (32'($urandom_range(63)) << 2) + 32'($urandom_range(3));
            1:       return 32'hFFFF_FFF0 | 32'($urandom_range(15));
            2:       return $urandom;
            default: return 32'h103;
        endcase
    endfunction

    task automatic step();
        bit         rv, redir, gnt, rdy, exp_req;
        int         inflight_cur;
        req_t       r;
        bit         do_push;
        logic [31:0] push_pc;
        @(negedge clk);
        cyc++;
        redir = force_redir || ($urandom_range(99) < 32'(redir_pct));
        gnt   = $urandom_range(99) < 32'(gnt_pct);
        rdy   = $urandom_range(99) < 32'(rdy_pct);
        rv    = 1'b0;
        if (pend.size() > 0) begin
            if (pend[0].due <= cyc && $urandom_range(99) < 32'(rv_pct)) rv = 1'b1;
        end
        bus.redirect    = redir;
        bus.redirect_pc = force_redir ? force_pc : pick_target();
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? mem_word(pend[0].addr) : $urandom;
        bus.ins_ready   = rdy;
        #1;
        inflight_cur = 0;
        foreach (pend[i]) if (pend[i].epoch == epoch) inflight_cur++;
        exp_req = !redir && (pend.size() < MAX_OUT) && (q_pc.size() + inflight_cur < DEPTH);
        chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", bus.imem_addr, m_fetch);
        chk("count", 32'(bus.count), 32'(q_pc.size()));
        chk("ins_valid", 32'(bus.ins_valid), 32'(q_pc.size() > 0));
        if (q_pc.size() > 0) begin
            chk("pc",   bus.PC,   q_pc[0]);
            chk("ins",  bus.ins,  mem_word(q_pc[0]));
            chk("pcp4", bus.PCp4, q_pc[0] + 32'd4);
        end
`ifdef FETCH_QUEUE_STATS_EN
        chk("stat_flushed", 32'(bus.stat_flushed), 32'(m_flushed));
        chk("stat_starve",  32'(bus.stat_starve),  32'(m_starve));
        if (m_delivered && q_pc.size() == 0 && !redir) m_starve++;
`endif
        // Model the effect of the coming edge.
        do_push = 1'b0;
        push_pc = '0;
        if (rv) begin
            r = pend.pop_front();
            if (r.epoch == epoch && !redir) begin
                do_push = 1'b1;
                push_pc = r.addr;
            end else begin
                m_flushed++;
            end
        end
        if (!redir && rdy && q_pc.size() > 0) begin
            void'(q_pc.pop_front());
            m_delivered = 1;
        end
        if (do_push) q_pc.push_back(push_pc);
        if (exp_req && gnt) begin
            r.addr  = m_fetch;
            r.epoch = epoch;
            r.due   = cyc + 1 + $urandom_range(max_lat);
            if (r.due < last_due) r.due = last_due;
            last_due = r.due;
            pend.push_back(r);
            m_fetch = m_fetch + 32'd4;
        end
        if (redir) begin
            m_flushed += q_pc.size();
            q_pc.delete();
            epoch++;
            m_fetch = bus.redirect_pc & 32'hFFFF_FFFC;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect_once(input logic [31:0] pc);
        force_redir = 1'b1;
        force_pc    = pc;
        step();
        force_redir = 1'b0;
    endtask

    task automatic set_knobs(input int g, input int v, input int l, input int d, input int x);
        gnt_pct = g; rv_pct = v; max_lat = l; rdy_pct = d; redir_pct = x;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        drive_idle();
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst         = 1'b1;
        cyc         = 0;
        force_redir = 1'b0;
        force_pc    = '0;
        drive_idle();
        model_reset();
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Streaming fill, then a decode stall that must saturate the queue.
        set_knobs(100, 100, 0, 100, 0);
        run(30);
        set_knobs(100, 100, 0, 0, 0);
        run(10);
        chk("stall_count", 32'(bus.count), 32'(DEPTH));
        chk("stall_req",   32'(bus.imem_req), 32'd0);
        set_knobs(100, 100, 1, 100, 0);
        run(20);

        // Redirect with a full queue and requests in flight, then odd/wrap targets.
        set_knobs(100, 100, 2, 0, 0);
        run(8);
        redirect_once(32'h100);
        set_knobs(100, 100, 0, 100, 0);
        run(12);
        redirect_once(32'h103);
        run(12);
        redirect_once(32'hFFFF_FFFC);
        run(12);

        for (int blk = 0; blk < 15; blk++) begin
            set_knobs($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(3),
                      $urandom_range(0, 100), $urandom_range(0, 8));
            run(200);
        end

        set_knobs(100, 100, 1, 30, 0);
        run(15);
        mid_reset();
        set_knobs(80, 80, 2, 70, 4);
        run(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
